// File: rtl/rx_iq3_collect_pkg.sv
// rx_iq3_collect_pkg: shared constants, iq3 word selectors and helpers for the rx I/Q collector
package rx_iq3_collect_pkg;
   localparam int NRX_DEF = 4;
   localparam int IQW = 24;
   typedef enum logic [1:0] {W_IHI = 2'd0, W_QHI = 2'd1, W_LO = 2'd2} word_e;
   function automatic logic [3:0] eff_chans(input logic [2:0] c, input int nrx);
      int e;
      e = (c == 3'd0) ? 1 : int'(c);
      return 4'((e > nrx) ? nrx : e);
   endfunction
   function automatic logic [15:0] iq3_word(input logic [IQW-1:0] i, input logic [IQW-1:0] q, input word_e w);
      return (w == W_IHI) ? i[IQW-1 -: 16] : (w == W_QHI) ? q[IQW-1 -: 16] : {i[7:0], q[7:0]};
   endfunction
endpackage

// File: rtl/rx_iq_hold.sv
// rx_iq_hold: one channel's I/Q hold registers and got flag; a new strobe wins over a set clear
module rx_iq_hold
   import rx_iq3_collect_pkg::*;
(
   input  logic           adc_clk,
   input  logic           reset,
   input  logic           strobe,
   input  logic           clr,
   input  logic [IQW-1:0] din_i,
   input  logic [IQW-1:0] din_q,
   output logic [IQW-1:0] hold_i,
   output logic [IQW-1:0] hold_q,
   output logic           got
);
   always_ff @(posedge adc_clk) begin
      if (reset) begin
         hold_i <= '0;
         hold_q <= '0;
         got <= 1'b0;
      end else begin
         if (strobe) begin
            hold_i <= din_i;
            hold_q <= din_q;
         end
         got <= strobe | (got & ~clr);
      end
   end
endmodule

// File: rtl/rx_iq3_collect.sv
// rx_iq3_collect: banks one I/Q sample per active rx channel and serves it as three 16-bit words
module rx_iq3_collect
   import rx_iq3_collect_pkg::*;
#(
   parameter int NRX = NRX_DEF
) (
   input  logic               adc_clk,
   input  logic               reset,
   input  logic [2:0]         rx_chans,
   input  logic [NRX-1:0]     rx_strobe,
   input  logic [NRX*IQW-1:0] rx_i,
   input  logic [NRX*IQW-1:0] rx_q,
   input  logic               rd_getI,
   input  logic               rd_getQ,
   output logic               rx_avail_A,
   output logic [15:0]        rx_dout_A,
   output logic               busy,
   output logic [7:0]         overrun_cnt
);
   logic [3:0] n_act;
   logic [2:0] last, ptr;
   logic [NRX-1:0] active, got;
   logic complete, q_d;
   logic [IQW-1:0] hold_i [NRX];
   logic [IQW-1:0] hold_q [NRX];
   logic [IQW-1:0] bank_i [NRX];
   logic [IQW-1:0] bank_q [NRX];
   logic [IQW-1:0] sel_i, sel_q;
   word_e wsel;
   assign n_act = eff_chans(rx_chans, NRX);
   assign last = 3'(n_act - 4'd1);
   assign complete = &(got | ~active);
   generate
      for (genvar n = 0; n < NRX; n++) begin : g_ch
         assign active[n] = 4'(n) < n_act;
         rx_iq_hold u_hold (
            .adc_clk(adc_clk),
            .reset(reset),
            .strobe(rx_strobe[n] & active[n]),
            .clr(complete),
            .din_i(rx_i[IQW*n +: IQW]),
            .din_q(rx_q[IQW*n +: IQW]),
            .hold_i(hold_i[n]),
            .hold_q(hold_q[n]),
            .got(got[n])
         );
      end
   endgenerate
   // ">=" on the wrap lets ptr recover if rx_chans shrinks mid-read
   always_ff @(posedge adc_clk) begin
      if (reset) begin
         rx_avail_A <= 1'b0;
         busy <= 1'b0;
         overrun_cnt <= '0;
         ptr <= '0;
         q_d <= 1'b0;
         for (int n = 0; n < NRX; n++) begin
            bank_i[n] <= '0;
            bank_q[n] <= '0;
         end
      end else begin
         rx_avail_A <= 1'b0;
         q_d <= rd_getQ;
         if (q_d) begin
            ptr <= (ptr >= last) ? 3'd0 : ptr + 3'd1;
            if (ptr >= last) busy <= 1'b0;
         end
         if (complete && !busy) begin
            for (int n = 0; n < NRX; n++) begin
               bank_i[n] <= hold_i[n];
               bank_q[n] <= hold_q[n];
            end
            busy <= 1'b1;
            rx_avail_A <= 1'b1;
         end else if (complete && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end
      end
   end
   always_comb begin
      sel_i = '0;
      sel_q = '0;
      for (int n = 0; n < NRX; n++) begin
         if (ptr == 3'(n)) begin
            sel_i = bank_i[n];
            sel_q = bank_q[n];
         end
      end
      wsel = rd_getI ? W_IHI : rd_getQ ? W_QHI : W_LO;
      rx_dout_A = iq3_word(sel_i, sel_q, wsel);
   end
endmodule

// File: tb/tb_rx_iq3_collect.sv
// tb_rx_iq3_collect: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_rx_iq3_collect;
   localparam int NRX = 4;
   typedef struct {
      string nm;
      int sel;
      logic [15:0] v;
   } exp_t;
   logic adc_clk = 1'b0;
   logic reset;
   logic [2:0] rx_chans;
   logic [NRX-1:0] rx_strobe;
   logic [NRX*24-1:0] rx_i, rx_q;
   logic rd_getI, rd_getQ;
   logic rx_avail_A, busy;
   logic [15:0] rx_dout_A;
   logic [7:0] overrun_cnt;
   exp_t exp_q[$];
   exp_t e;
   logic [15:0] act;
   int mon_n = 0;
   int total = 0;
   int bad = 0;
   logic [15:0] wa [4][3];
   logic [15:0] wb [4][3];
   rx_iq3_collect #(.NRX(NRX)) dut (
      .adc_clk(adc_clk),
      .reset(reset),
      .rx_chans(rx_chans),
      .rx_strobe(rx_strobe),
      .rx_i(rx_i),
      .rx_q(rx_q),
      .rd_getI(rd_getI),
      .rd_getQ(rd_getQ),
      .rx_avail_A(rx_avail_A),
      .rx_dout_A(rx_dout_A),
      .busy(busy),
      .overrun_cnt(overrun_cnt)
   );
   always #5 adc_clk = ~adc_clk;
   always @(negedge adc_clk) begin
      for (int k = 0; k < mon_n; k++) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: empty queue, got nothing want item %0d", k);
         end else begin
            e = exp_q.pop_front();
            act = (e.sel == 0) ? rx_dout_A : (e.sel == 1) ? 16'(rx_avail_A) : (e.sel == 2) ? 16'(busy) : {8'h00, overrun_cnt};
            if (act !== e.v) begin
               bad++;
               $display("FAIL %s: got %h want %h at %0t", e.nm, act, e.v, $time);
            end
         end
      end
   end
   task automatic tick;
      @(posedge adc_clk);
      #1;
      mon_n = 0;
   endtask
   task automatic expect_item(input string nm, input int sel, input logic [15:0] v);
      exp_q.push_back('{nm, sel, v});
      mon_n++;
   endtask
   task automatic status(input logic av, input logic bz, input logic [7:0] ov);
      expect_item("avail", 1, 16'(av));
      expect_item("busy", 2, 16'(bz));
      expect_item("overrun", 3, 16'(ov));
   endtask
   task automatic strobe(input logic [NRX-1:0] m, input int ib, input int qb);
      for (int n = 0; n < NRX; n++) begin
         rx_i[24*n +: 24] = 24'(ib * (n + 1));
         rx_q[24*n +: 24] = 24'(qb - n);
      end
      rx_strobe = m;
      tick;
      rx_strobe = '0;
   endtask
   task automatic rd_chan(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
      rd_getI = 1'b1;
      expect_item("word_ihi", 0, w0);
      tick;
      rd_getI = 1'b0;
      rd_getQ = 1'b1;
      expect_item("word_qhi", 0, w1);
      tick;
      rd_getQ = 1'b0;
      expect_item("word_lo", 0, w2);
      tick;
   endtask
   task automatic rd_set(input bit b, input int nch);
      for (int c = 0; c < nch; c++) begin
         if (b) rd_chan(wb[c][0], wb[c][1], wb[c][2]);
         else rd_chan(wa[c][0], wa[c][1], wa[c][2]);
      end
   endtask
   localparam int IA = 'h123456, QA = 'hABCDEF, IB = 'h0F0F0F, QB = 'h102030;
   initial begin
      wa = '{'{16'h1234, 16'hABCD, 16'h56EF}, '{16'h2468, 16'hABCD, 16'hACEE},
             '{16'h369D, 16'hABCD, 16'h02ED}, '{16'h48D1, 16'hABCD, 16'h58EC}};
      wb = '{'{16'h0F0F, 16'h1020, 16'h0F30}, '{16'h1E1E, 16'h1020, 16'h1E2F},
             '{16'h2D2D, 16'h1020, 16'h2D2E}, '{16'h3C3C, 16'h1020, 16'h3C2D}};
      reset = 1'b1;
      rx_chans = 3'd4;
      rx_strobe = '0;
      rx_i = '0;
      rx_q = '0;
      rd_getI = 1'b0;
      rd_getQ = 1'b0;
      repeat (3) tick;
      reset = 1'b0;
      status(1'b0, 1'b0, 8'd0);
      expect_item("reset_dout", 0, 16'h0000);
      tick;
      // full 4-channel set, avail two cycles after the last strobe
      strobe(4'h1, IA, QA);
      strobe(4'h2, IA, QA);
      strobe(4'h4, IA, QA);
      status(1'b0, 1'b0, 8'd0);
      strobe(4'h8, IA, QA);
      status(1'b0, 1'b0, 8'd0);
      tick;
      status(1'b1, 1'b1, 8'd0);
      tick;
      status(1'b0, 1'b1, 8'd0);
      rd_set(1'b0, 3);
      status(1'b0, 1'b1, 8'd0);
      rd_chan(wa[3][0], wa[3][1], wa[3][2]);
      status(1'b0, 1'b0, 8'd0);
      tick;
      // second set completing while busy is dropped
      strobe(4'hF, IA, QA);
      tick;
      status(1'b1, 1'b1, 8'd0);
      tick;
      strobe(4'hF, IB, QB);
      status(1'b0, 1'b1, 8'd0);
      tick;
      status(1'b0, 1'b1, 8'd1);
      rd_set(1'b0, 4);
      status(1'b0, 1'b0, 8'd1);
      tick;
      // ch0 strobe on the bank-load edge starts the next set
      strobe(4'hF, IA, QA);
      strobe(4'h1, IB, QB);
      status(1'b1, 1'b1, 8'd1);
      tick;
      rd_set(1'b0, 4);
      status(1'b0, 1'b0, 8'd1);
      strobe(4'hE, IB, QB);
      status(1'b0, 1'b0, 8'd1);
      tick;
      status(1'b1, 1'b1, 8'd1);
      tick;
      rd_set(1'b1, 4);
      // two active channels, strobes on ch2/ch3 ignored
      rx_chans = 3'd2;
      tick;
      strobe(4'h1, IA, QA);
      strobe(4'h2, IA, QA);
      tick;
      status(1'b1, 1'b1, 8'd1);
      strobe(4'h4, IB, QB);
      strobe(4'h8, IB, QB);
      status(1'b0, 1'b1, 8'd1);
      rd_set(1'b0, 2);
      status(1'b0, 1'b0, 8'd1);
      rd_chan(wa[0][0], wa[0][1], wa[0][2]);
      // reset in the middle of a read
      rx_chans = 3'd4;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      strobe(4'hF, IA, QA);
      tick;
      tick;
      rd_chan(wa[0][0], wa[0][1], wa[0][2]);
      rd_getI = 1'b1;
      expect_item("word_ihi", 0, wa[1][0]);
      tick;
      rd_getI = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      status(1'b0, 1'b0, 8'd0);
      expect_item("post_reset_dout", 0, 16'h0000);
      strobe(4'hF, IB, QB);
      tick;
      status(1'b1, 1'b1, 8'd0);
      tick;
      rd_set(1'b1, 4);
      status(1'b0, 1'b0, 8'd0);
      // rx_chans=0 acts as a single channel
      rx_chans = 3'd0;
      tick;
      strobe(4'h1, IA, QA);
      tick;
      status(1'b1, 1'b1, 8'd0);
      tick;
      rd_chan(wa[0][0], wa[0][1], wa[0][2]);
      status(1'b0, 1'b0, 8'd0);
      strobe(4'h2, IB, QB);
      status(1'b0, 1'b0, 8'd0);
      strobe(4'h1, IB, QB);
      tick;
      status(1'b1, 1'b1, 8'd0);
      tick;
      rd_chan(wb[0][0], wb[0][1], wb[0][2]);
      status(1'b0, 1'b0, 8'd0);
      // overrun counter saturation
      rx_chans = 3'd4;
      tick;
      strobe(4'hF, IA, QA);
      tick;
      status(1'b1, 1'b1, 8'd0);
      repeat (300) strobe(4'hF, IB, QB);
      tick;
      status(1'b0, 1'b1, 8'd255);
      repeat (2) tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
